dmem_port_arbiter: RTL
======================

Name: dmem_port_arbiter

Overview:
- Shares the single-port data memory between two requesters:
  - the instruction-fetch side (IF port);
  - the load/store side of the MEM stage (LS port).
- Issues one access at a time, tracks the memory's fixed read latency and returns read data to the owner.
- LS has priority by default. A starvation counter guarantees that IF makes forward progress.
- Sits between the pipeline stages and the data memory instance, replacing the direct MEM-stage hookup.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MEM_LAT, 1, cycles from the read issue cycle to valid dm_rdata (>=1).
- MAX_WAIT, 4, consecutive denied IF-request cycles before IF is forced to win (>=1).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- if_req  in  1  IF read request; held with if_addr stable until if_gnt.
- if_addr  in  ADDR_W  IF read address.
- if_gnt  out  1  IF request accepted this cycle.
- if_rvalid  out  1  one-cycle pulse; if_rdata valid.
- if_rdata  out  DATA_W  IF read data.
- ls_req  in  1  LS request; held with ls_we/ls_addr/ls_wdata stable until ls_gnt.
- ls_we  in  1  1 = store, 0 = load.
- ls_addr  in  ADDR_W  LS address.
- ls_wdata  in  DATA_W  store data.
- ls_gnt  out  1  LS request accepted this cycle.
- ls_rvalid  out  1  one-cycle pulse; ls_rdata valid (loads only).
- ls_rdata  out  DATA_W  load data.
- dm_addr  out  ADDR_W  memory address.
- dm_wdata  out  DATA_W  memory write data.
- dm_we  out  1  memory write enable, one cycle per store.
- dm_re  out  1  memory read enable, one cycle per load/fetch.
- dm_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after dm_re.

Behaviour:
- **Reset** (reset=1 at the edge):
  - State IDLE; starv_cnt=0; lat_cnt=0; owner=LS.
  - All outputs 0: gnt, rvalid, dm_we, dm_re, rdata, dm_addr, dm_wdata.
- **FSM states.**
  - IDLE: free; an access may issue this cycle.
  - RD_WAIT: read outstanding; no new issue.
- **Issue (IDLE only).**
  - Grant, dm_re/dm_we and dm_addr/dm_wdata are combinational in the same cycle. At most one gnt is high per cycle.
  - Selection:
    - Only one req high: that port wins.
    - Both high and starv_cnt < MAX_WAIT: LS wins.
    - Both high and starv_cnt == MAX_WAIT: IF wins.
  - LS store granted: dm_we=1, dm_re=0, state stays IDLE. A new grant is allowed on the next cycle (back-to-back stores at full rate). There is no rvalid for stores.
  - Read granted (IF or LS load): dm_re=1, owner latched, lat_cnt=MEM_LAT, go to RD_WAIT.
- **RD_WAIT.**
  - gnt=0, dm_re=0, dm_we=0.
  - dm_addr holds the issued address; dm_wdata is don't-care.
  - lat_cnt decrements each cycle.
  - In the cycle lat_cnt reaches 0 (exactly MEM_LAT cycles after the issue cycle):
    - dm_rdata is captured into the owner's rdata register.
    - The owner's rvalid pulses for one cycle.
    - State returns to IDLE.
  - Arbitration resumes in the cycle after the rvalid pulse. Throughput for reads is one per MEM_LAT+1 cycles.
- **rdata hold.** if_rdata/ls_rdata hold their last value until the next capture for that port.
- **Starvation counter.**
  - Increments (saturating at MAX_WAIT) in every cycle where if_req=1 and if_gnt=0, including RD_WAIT cycles.
  - Clears on if_gnt.
  - Holds when if_req=0.
- **Edge cases.**
  - Requests are sampled only in IDLE; a req rising during RD_WAIT waits.
  - A requester may drop req before gnt; no grant is issued for it.
  - If both req fall to 0 in IDLE: no memory enable, no state change.
- **Reset mid-operation.** Reset during RD_WAIT:
  - aborts the read;
  - no rvalid is produced, even if MEM_LAT would expire on that edge;
  - the returning dm_rdata is ignored.
- **Address and data pass-through.** Address and data pass through unmodified; no alignment checks or width conversion.

Test Plan:
- **Reset values.** Assert reset 2 cycles with if_req=ls_req=1 → all gnt/rvalid/dm_re/dm_we=0. Deassert → LS granted first cycle.
- **Single fetch, MEM_LAT=1.** if_req=1, if_addr=0x100, memory returns 0xDEADBEEF.
  - Required: if_gnt and dm_re at cycle t, dm_addr=0x100.
  - Required: if_rvalid at t+1, if_rdata=0xDEADBEEF.
  - Required: next grant no earlier than t+2.
- **Back-to-back stores.** ls_req=1, ls_we=1 for addrs 0x10, 0x14, 0x18 with wdata 1, 2, 3.
  - Required: dm_we high 3 consecutive cycles with matching addr/wdata.
  - Required: ls_rvalid never asserted.
- **Priority and starvation, MAX_WAIT=4.** Both req held high continuously, LS issuing stores.
  - Required: LS granted 4 consecutive cycles, IF granted on the 5th, starv_cnt back to 0.
  - Repeat with LS loads, MEM_LAT=2: IF is granted after starv_cnt hits 4, counting RD_WAIT cycles.
- **Load, MEM_LAT=3.** ls load to 0x20, memory returns 0x12345678.
  - Required: ls_rvalid exactly 3 cycles after ls_gnt, ls_rdata=0x12345678.
  - Required: if_rvalid stays 0 and if_req is not granted during the wait.
- **Reset mid-read, MEM_LAT=3.** Assert reset one cycle after if_gnt.
  - Required: no if_rvalid ever for that access.
  - Required: FSM in IDLE; a fresh request is granted in the first cycle after reset deasserts.

Source files
------------

// File: rtl/dmem_port_arbiter.sv
// Shares one data-memory port between instruction fetch (IF) and load/store (LS).
// LS has priority; a saturating starvation counter forces IF through after MAX_WAIT denials.
module dmem_port_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MEM_LAT  = 1,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_gnt,
  output logic              ls_rvalid,
  output logic [DATA_W-1:0] ls_rdata,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_wdata,
  output logic              dm_we,
  output logic              dm_re,
  input  logic [DATA_W-1:0] dm_rdata
);

  localparam int LW = $clog2(MEM_LAT + 1);
  localparam int SW = $clog2(MAX_WAIT + 1);

  typedef enum logic {
    IDLE,
    RD_WAIT
  } state_t;

  state_t            state_q, state_d;
  logic [LW-1:0]     lat_cnt_q, lat_cnt_d;
  logic [SW-1:0]     starv_cnt_q, starv_cnt_d;
  logic              owner_if_q, owner_if_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] ls_rdata_q, ls_rdata_d;
  logic              starved;

  always_comb begin
    state_d     = state_q;
    lat_cnt_d   = lat_cnt_q;
    owner_if_d  = owner_if_q;
    addr_d      = addr_q;
    if_rdata_d  = if_rdata_q;
    ls_rdata_d  = ls_rdata_q;
    if_gnt      = 1'b0;
    ls_gnt      = 1'b0;
    if_rvalid   = 1'b0;
    ls_rvalid   = 1'b0;
    dm_we       = 1'b0;
    dm_re       = 1'b0;
    dm_addr     = addr_q;
    dm_wdata    = '0;
    starved     = (starv_cnt_q == SW'(MAX_WAIT));

    // Grants and read-data returns are suppressed while reset is high so that
    // outputs read zero and an aborted read never reports completion.
    case (state_q)
      IDLE: begin
        if (!reset) begin
          if (if_req && (!ls_req || starved)) begin
            if_gnt = 1'b1;
          end else if (ls_req) begin
            ls_gnt = 1'b1;
          end
        end
        if (if_gnt) begin
          dm_re      = 1'b1;
          dm_addr    = if_addr;
          addr_d     = if_addr;
          owner_if_d = 1'b1;
          lat_cnt_d  = LW'(MEM_LAT);
          state_d    = RD_WAIT;
        end else if (ls_gnt) begin
          dm_addr = ls_addr;
          addr_d  = ls_addr;
          if (ls_we) begin
            dm_we    = 1'b1;
            dm_wdata = ls_wdata;
          end else begin
            dm_re      = 1'b1;
            owner_if_d = 1'b0;
            lat_cnt_d  = LW'(MEM_LAT);
            state_d    = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        lat_cnt_d = lat_cnt_q - 1'b1;
        if (lat_cnt_q == LW'(1)) begin
          state_d = IDLE;
          if (!reset) begin
            if (owner_if_q) begin
              if_rvalid  = 1'b1;
              if_rdata_d = dm_rdata;
            end else begin
              ls_rvalid  = 1'b1;
              ls_rdata_d = dm_rdata;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Returned data is forwarded in the pulse cycle and held from the register afterwards.
    if_rdata = if_rvalid ? dm_rdata : if_rdata_q;
    ls_rdata = ls_rvalid ? dm_rdata : ls_rdata_q;

    if (if_gnt) begin
      starv_cnt_d = '0;
    end else if (if_req && !starved) begin
      starv_cnt_d = starv_cnt_q + 1'b1;
    end else begin
      starv_cnt_d = starv_cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      lat_cnt_q   <= '0;
      starv_cnt_q <= '0;
      owner_if_q  <= 1'b0;
      addr_q      <= '0;
      if_rdata_q  <= '0;
      ls_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      lat_cnt_q   <= lat_cnt_d;
      starv_cnt_q <= starv_cnt_d;
      owner_if_q  <= owner_if_d;
      addr_q      <= addr_d;
      if_rdata_q  <= if_rdata_d;
      ls_rdata_q  <= ls_rdata_d;
    end
  end

endmodule
